// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating direction
// counters. Fetch looks up vpc_i combinationally. EX writes back resolved
// branches through branch_predict_i.
// Optional build macro: BTB_BYPASS_EN forwards a same-cycle update to a
// lookup at the same index.

package btb_pkg;

    // Resolution record sent back by EX after a control-flow instruction resolves.
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        logic        is_lower_16;
        logic        clear;
    } branchpredict;

    // Prediction hint that fetch attaches to fetch_entry.branch_predict.
    typedef struct packed {
        logic        valid;
        logic        predict_taken;
        logic [63:0] predict_address;
        logic        is_lower_16;
    } branchpredict_sbe;

endpackage

module branch_target_buffer #(
    parameter int NR_ENTRIES = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [63:0]              vpc_i,
    input  btb_pkg::branchpredict     branch_predict_i,
    output btb_pkg::branchpredict_sbe branch_predict_o
);

    localparam int INDEX_BITS = $clog2(NR_ENTRIES);
    localparam int TAG_BITS   = 64 - INDEX_BITS - 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [63:0]         target;
        logic [1:0]          cnt;
        logic                is_lower_16;
    } btb_entry_t;

    btb_entry_t r_table [NR_ENTRIES];

    logic [INDEX_BITS-1:0] w_lookup_idx;
    logic [TAG_BITS-1:0]   w_lookup_tag;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    btb_entry_t            w_upd_old;
    btb_entry_t            w_upd_new;
    logic                  w_upd_hit;
    btb_entry_t            w_rd_entry;
    logic                  w_lookup_hit;
    logic                  w_unused_bits;

    // Bit 0 is never part of index or tag: instructions are at least 16-bit aligned.
    assign w_lookup_idx  = vpc_i[INDEX_BITS:1];
    assign w_lookup_tag  = vpc_i[63:INDEX_BITS+1];
    assign w_upd_idx     = branch_predict_i.pc[INDEX_BITS:1];
    assign w_upd_tag     = branch_predict_i.pc[63:INDEX_BITS+1];
    assign w_upd_old     = r_table[w_upd_idx];
    assign w_upd_hit     = w_upd_old.valid && (w_upd_old.tag == w_upd_tag);
    assign w_unused_bits = vpc_i[0] ^ branch_predict_i.pc[0];

    // Two-bit saturating counter step: taken counts up, not-taken counts down.
    function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
        logic [1:0] next;
        next = cnt;
        if (taken && cnt != 2'b11) begin
            next = cnt + 2'd1;
        end else if (!taken && cnt != 2'b00) begin
            next = cnt - 2'd1;
        end
        return next;
    endfunction

    // Compute the value the indexed entry takes if the update is applied.
    always_comb begin
        // NOTE: start from the current entry so every path assigns every field;
        // a missing default here would infer a latch.
        w_upd_new = w_upd_old;
        if (branch_predict_i.clear) begin
            w_upd_new.valid = 1'b0;
        end else if (branch_predict_i.is_mispredict && w_upd_hit) begin
            w_upd_new.cnt = sat_cnt(w_upd_old.cnt, branch_predict_i.is_taken);
            if (branch_predict_i.is_taken) begin
                w_upd_new.target      = branch_predict_i.target_address;
                w_upd_new.is_lower_16 = branch_predict_i.is_lower_16;
            end
        end else if (branch_predict_i.is_mispredict) begin
            // Allocate, evicting whatever alias sat at this index.
            w_upd_new.valid       = 1'b1;
            w_upd_new.tag         = w_upd_tag;
            w_upd_new.target      = branch_predict_i.target_address;
            w_upd_new.is_lower_16 = branch_predict_i.is_lower_16;
            w_upd_new.cnt         = branch_predict_i.is_taken ? 2'b10 : 2'b01;
        end else if (w_upd_hit) begin
            w_upd_new.cnt = sat_cnt(w_upd_old.cnt, branch_predict_i.is_taken);
        end
    end

    // Table state: reset clears everything, flush drops valid bits, else apply one update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the table is reset in full (not just valid bits) so that
            // the prediction output is all zeros while reset is held.
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_table[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_table[i].valid <= 1'b0;
            end
        end else if (branch_predict_i.valid) begin
            // NOTE: state is written with non-blocking assignments so every
            // reader in this cycle sees the pre-edge value.
            r_table[w_upd_idx] <= w_upd_new;
        end
    end

    // Combinational lookup for the fetch PC, optionally forwarding this cycle's update.
    always_comb begin
        w_rd_entry = r_table[w_lookup_idx];
`ifdef BTB_BYPASS_EN
        if (branch_predict_i.valid && !flush_i && !rst_i && (w_upd_idx == w_lookup_idx)) begin
            w_rd_entry = w_upd_new;
        end
`endif
        w_lookup_hit = w_rd_entry.valid && (w_rd_entry.tag == w_lookup_tag);

        branch_predict_o.valid           = w_lookup_hit;
        branch_predict_o.predict_taken   = w_lookup_hit && w_rd_entry.cnt[1];
        branch_predict_o.predict_address = w_rd_entry.target;
        branch_predict_o.is_lower_16     = w_rd_entry.is_lower_16;
    end

endmodule
